// File: rtl/multicycle_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - ALU operation codes driven onto the 4-bit alu_control bus
//   - base opcodes recognised by the decoder
//   - FSM state encoding, immediate-format encoding, ALU-op class
//   - helpers mapping an opcode to its immediate format and checking
//     which branch funct3 values are implemented
// ---------------------------------------------------------------------------
package multicycle_pkg;

  typedef logic [3:0] alu_code_t;

  localparam alu_code_t ALU_ADD  = 4'h0;
  localparam alu_code_t ALU_SUB  = 4'h1;
  localparam alu_code_t ALU_AND  = 4'h2;
  localparam alu_code_t ALU_OR   = 4'h3;
  localparam alu_code_t ALU_XOR  = 4'h4;
  localparam alu_code_t ALU_SLL  = 4'h5;
  localparam alu_code_t ALU_SRL  = 4'h6;
  localparam alu_code_t ALU_SRA  = 4'h7;
  localparam alu_code_t ALU_EQ   = 4'h8;
  localparam alu_code_t ALU_ULT  = 4'h9;
  localparam alu_code_t ALU_UGTE = 4'hA;
  localparam alu_code_t ALU_SLT  = 4'hB;
  localparam alu_code_t ALU_SGTE = 4'hC;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  // Class of ALU operation requested by the FSM; the decoder turns the
  // class plus funct fields into the concrete code.
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_BRANCH = 2'd1,
    ALUOP_RTYPE  = 2'd2,
    ALUOP_ITYPE  = 2'd3
  } alu_op_t;

  // R-type and unknown opcodes have no immediate; I format is reported.
  function automatic imm_src_t imm_for_op(input logic [6:0] op);
    imm_src_t imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

  // funct3 010 and 011 are not defined branch conditions.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the control FSM and the datapath.
//   Datapath -> control : op, funct3, funct7b5, alu_zero_n, mem_ready
//   Control -> datapath : pc_write, adr_src, mem_write, ir_write,
//                         result_src, alu_src_a, alu_src_b, imm_src,
//                         reg_write, alu_control, illegal
// master = control unit side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  alu_zero_n;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic [1:0]            result_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            imm_src;
  logic                  reg_write;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal;

  modport master (
    input  op, funct3, funct7b5, alu_zero_n, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal
  );

  modport slave (
    output op, funct3, funct7b5, alu_zero_n, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational map from {ALU-op class, funct3, funct7b5} to an ALU code.
//   i_alu_op      : operation class chosen by the FSM
//   i_funct3      : instruction[14:12]
//   i_funct7b5    : instruction[30]
//   o_alu_control : ALU operation code
//   o_branch_inv  : 1 when the branch condition is the inverse of the
//                   ALU compare result (bne)
// ---------------------------------------------------------------------------
module alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_code_t  o_alu_control,
  output logic       o_branch_inv
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_branch_inv  = 1'b0;
    case (i_alu_op)
      ALUOP_BRANCH: begin
        case (i_funct3)
          3'b000:  o_alu_control = ALU_EQ;
          3'b001: begin
            o_alu_control = ALU_EQ;
            o_branch_inv  = 1'b1;
          end
          3'b100:  o_alu_control = ALU_SLT;
          3'b101:  o_alu_control = ALU_SGTE;
          3'b110:  o_alu_control = ALU_ULT;
          3'b111:  o_alu_control = ALU_UGTE;
          default: o_alu_control = ALU_EQ;
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (i_funct3)
          // addi carries immediate bits in funct7, so only R-type may SUB
          3'b000:  o_alu_control = (i_alu_op == ALUOP_RTYPE && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_ULT;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle RV32I control FSM: sequences fetch / decode / execute /
// memory / writeback and drives the ALU operation code.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   ctrl  : control bundle (master side), see multicycle_control_if
// Outputs are combinational from state and inputs. Enables are gated by
// rst_n so nothing is written while reset is held.
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master ctrl
);

  state_t     r_state;
  state_t     w_state_next;

  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  imm_src_t   w_imm_src;
  logic       w_reg_write;
  logic       w_illegal;
  alu_op_t    w_alu_op;
  alu_code_t  w_alu_code;
  logic       w_branch_inv;

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (ctrl.funct3),
    .i_funct7b5    (ctrl.funct7b5),
    .o_alu_control (w_alu_code),
    .o_branch_inv  (w_branch_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_alu_op     = ALUOP_ADD;
    // The instruction register is only meaningful once fetch is done.
    w_imm_src    = (r_state == S_FETCH) ? IMM_I : imm_for_op(ctrl.op);

    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = ctrl.mem_ready;
        w_pc_write   = ctrl.mem_ready;
        if (ctrl.mem_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // PC-relative target computed here and parked in ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (ctrl.op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_JAL:            w_state_next = S_JAL;
          OP_LUI:            w_state_next = S_LUI;
          OP_BRANCH: begin
            if (branch_f3_legal(ctrl.funct3)) begin
              w_state_next = S_BRANCH;
            end else begin
              w_illegal    = 1'b1;
              w_state_next = S_FETCH;
            end
          end
          default: begin
            w_illegal    = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_state_next = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (ctrl.mem_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (ctrl.mem_ready) w_state_next = S_FETCH;
      end
      S_EXECR: begin
        w_alu_src_a  = 2'b10;
        w_alu_op     = ALUOP_RTYPE;
        w_state_next = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_alu_op     = ALUOP_ITYPE;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        // ALU forms the link value while ALUOut (target) loads the PC.
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_pc_write   = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_alu_op     = ALUOP_BRANCH;
        w_pc_write   = ctrl.alu_zero_n ^ w_branch_inv;
        w_state_next = S_FETCH;
      end
      S_LUI: begin
        w_alu_src_a  = 2'b11;
        w_alu_src_b  = 2'b01;
        w_state_next = S_ALUWB;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // Async reset forces FETCH selects; enables are also masked by rst_n so
  // FETCH's mem_ready-driven writes cannot fire while reset is held.
  assign ctrl.pc_write    = w_pc_write  & rst_n;
  assign ctrl.ir_write    = w_ir_write  & rst_n;
  assign ctrl.mem_write   = w_mem_write & rst_n;
  assign ctrl.reg_write   = w_reg_write & rst_n;
  assign ctrl.illegal     = w_illegal   & rst_n;
  assign ctrl.adr_src     = w_adr_src;
  assign ctrl.result_src  = w_result_src;
  assign ctrl.alu_src_a   = w_alu_src_a;
  assign ctrl.alu_src_b   = w_alu_src_b;
  assign ctrl.imm_src     = w_imm_src;
  assign ctrl.alu_control = ALU_CTRL_W'(w_alu_code);

endmodule
